// File: rtl/bit_change_arbiter_pkg.sv
// Shared types and defaults for the time-multiplexed bit-change detector.
package bit_change_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_ID_W  = 4;   // N_CH tops out at 16

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        EMIT
    } state_t;

    // Event record sized for the largest supported channel count.
    typedef struct packed {
        logic [MAX_ID_W-1:0] ch;
        logic                rise;
    } evt_t;

endpackage

// File: rtl/bit_change_arbiter_rr.sv
// Round-robin arbiter: search starts one past ptr and wraps modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] cidx;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cidx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cidx = ID_W'((int'(ptr) + i) % N_CH);
            if (!any && req[cidx]) begin
                any       = 1'b1;
                idx       = cidx;
                gnt[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_change_arbiter.sv
// One Moore bit-change detector shared across N_CH serial requesters, with
// per-channel context, saturating event counters and a valid/ready event port.
module bit_change_arbiter
    import bit_change_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = $clog2(N_CH)
) (
    input  logic             Clk,
    input  logic             Clr_n,
    input  logic [N_CH-1:0]  Ch_en,
    input  logic [N_CH-1:0]  Req,
    input  logic [N_CH-1:0]  Bit,
    output logic [N_CH-1:0]  Ack,
    output logic             Evt_valid,
    input  logic             Evt_ready,
    output logic [ID_W-1:0]  Evt_ch,
    output logic             Evt_rise,
    input  logic [ID_W-1:0]  Cnt_sel,
    output logic [CNT_W-1:0] Cnt_out
);

    state_t                       state, state_nxt;
    logic [ID_W-1:0]              ptr, cur_ch;
    logic                         cur_bit;
    logic [N_CH-1:0]              last, has_last;
    logic [N_CH-1:0][CNT_W-1:0]   cnt;

    logic [N_CH-1:0]              gnt;
    logic [ID_W-1:0]              gidx;
    logic                         gany;

    rr_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) u_rr (
        .req (Req & Ch_en),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gany) state_nxt = CMP;
            CMP:  state_nxt = (has_last[cur_ch] && (cur_bit != last[cur_ch])) ? EMIT : IDLE;
            EMIT: if (Evt_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state     <= IDLE;
            ptr       <= ID_W'(N_CH - 1);
            cur_ch    <= '0;
            cur_bit   <= 1'b0;
            Ack       <= '0;
            Evt_valid <= 1'b0;
            Evt_ch    <= '0;
            Evt_rise  <= 1'b0;
            last      <= '0;
            has_last  <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            Ack   <= '0;
            case (state)
                IDLE: if (gany) begin
                    cur_ch  <= gidx;
                    cur_bit <= Bit[gidx];
                    ptr     <= gidx;
                    Ack     <= gnt;
                end
                CMP: if (!has_last[cur_ch]) begin
                    last[cur_ch]     <= cur_bit;
                    has_last[cur_ch] <= 1'b1;
                end else if (cur_bit != last[cur_ch]) begin
                    Evt_valid    <= 1'b1;
                    Evt_ch       <= cur_ch;
                    Evt_rise     <= cur_bit;
                    last[cur_ch] <= cur_bit;
                end
                EMIT: if (Evt_ready) begin
                    Evt_valid <= 1'b0;
                    if (cnt[cur_ch] != '1)
                        cnt[cur_ch] <= cnt[cur_ch] + 1'b1;
                end
                default: ;
            endcase
            // Disabled channels lose context; this wins over a CMP update.
            for (int c = 0; c < N_CH; c++) begin
                if (!Ch_en[c]) begin
                    has_last[c] <= 1'b0;
                    last[c]     <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        Cnt_out = '0;
        if (int'(Cnt_sel) < N_CH)
            Cnt_out = cnt[Cnt_sel];
    end

endmodule

// File: tb/tb_bit_change_arbiter.sv
// Directed tables for the documented corner cases plus a randomized run
// scored against a transaction-level model of the detector.
module tb_bit_change_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          Clk = 1'b0;
    logic          Clr_n = 1'b0;
    logic [N-1:0]  Ch_en, Req, Bit, Ack, Ack_s;
    logic          Evt_valid, Evt_ready, Evt_rise, Evt_valid_s, Evt_rise_s;
    logic [IW-1:0] Evt_ch, Evt_ch_s, Cnt_sel;
    logic [7:0]    Cnt_out;
    logic [1:0]    Cnt_out_s;

    always #5 Clk = ~Clk;

    bit_change_arbiter #(.N_CH(N), .CNT_W(8)) u_dut (
        .Clk(Clk), .Clr_n(Clr_n), .Ch_en(Ch_en), .Req(Req), .Bit(Bit), .Ack(Ack),
        .Evt_valid(Evt_valid), .Evt_ready(Evt_ready), .Evt_ch(Evt_ch),
        .Evt_rise(Evt_rise), .Cnt_sel(Cnt_sel), .Cnt_out(Cnt_out)
    );

    bit_change_arbiter #(.N_CH(N), .CNT_W(2)) u_sat (
        .Clk(Clk), .Clr_n(Clr_n), .Ch_en(Ch_en), .Req(Req), .Bit(Bit), .Ack(Ack_s),
        .Evt_valid(Evt_valid_s), .Evt_ready(Evt_ready), .Evt_ch(Evt_ch_s),
        .Evt_rise(Evt_rise_s), .Cnt_sel(Cnt_sel), .Cnt_out(Cnt_out_s)
    );

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic b;
        logic ev;
        logic rise;
    } vec_t;

    typedef struct {
        int   ch;
        logic rise;
    } mevt_t;

    // transaction-level model state
    logic  m_has [N];
    logic  m_last[N];
    int    m_cnt [N];
    mevt_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Clr_n = 1'b0;
        Req = '0; Bit = '0; Ch_en = '1; Evt_ready = 1'b1; Cnt_sel = '0;
        repeat (2) @(negedge Clk);
        Clr_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic wait_ack(input int ch, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            if (Ack[ch]) got = 1'b1;
        end
        chk(name, got, 1);
    endtask

    // Offer one sample and report what the detector produced for it.
    task automatic send(input int ch, input logic b, output logic ev, output logic rise,
                        output logic [IW-1:0] evch);
        Req[ch] = 1'b1;
        Bit[ch] = b;
        wait_ack(ch, "send_ack");
        Req[ch] = 1'b0;
        @(negedge Clk);
        ev = Evt_valid; rise = Evt_rise; evch = Evt_ch;
        if (ev && Evt_ready) @(negedge Clk);
    endtask

    task automatic rand_cycle(input bit quiet);
        logic          acked, abit;
        int            ach;
        mevt_t         e;
        acked = 1'b0; abit = 1'b0; ach = 0;
        @(negedge Clk);
        chk("rnd_cnt", Cnt_out, m_cnt[Cnt_sel]);
        if (Ack != '0) begin
            chk("rnd_ack_onehot", $onehot(Ack), 1);
            chk("rnd_ack_eligible", (Ack & Req & Ch_en), Ack);
            for (int c = 0; c < N; c++) if (Ack[c]) ach = c;
            abit  = Bit[ach];
            acked = 1'b1;
        end
        for (int c = 0; c < N; c++) begin
            if (Ack[c] || !Req[c]) begin
                Req[c] = quiet ? 1'b0 : (($urandom % (Ack[c] ? 4 : 3)) == 0);
                Bit[c] = 1'($urandom % 2);
            end
            Ch_en[c] = quiet ? 1'b1 : (($urandom % 10) != 0);
        end
        Evt_ready = quiet ? 1'b1 : (($urandom % 3) != 0);
        Cnt_sel   = IW'($urandom % N);
        if (acked) begin
            if (!m_has[ach]) begin
                m_has[ach]  = 1'b1;
                m_last[ach] = abit;
            end else if (abit != m_last[ach]) begin
                exp_q.push_back('{ach, abit});
                m_last[ach] = abit;
            end
        end
        for (int c = 0; c < N; c++)
            if (!Ch_en[c]) begin m_has[c] = 1'b0; m_last[c] = 1'b0; end
        if (Evt_valid && Evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("rnd_evt_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rnd_evt_ch", Evt_ch, e.ch);
                chk("rnd_evt_rise", Evt_rise, e.rise);
                if (m_cnt[e.ch] < 255) m_cnt[e.ch]++;
            end
        end
    endtask

    initial begin
        vec_t          tv[5];
        int            exp_ack[10];
        logic          ev, rise;
        logic [IW-1:0] evch;

        tv[0] = '{1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b1};
        tv[3] = '{1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b0};
        exp_ack = '{1, 0, 2, 0, 4, 0, 8, 0, 1, 0};

        // reset values
        Req = '0; Bit = '0; Ch_en = '1; Evt_ready = 1'b1; Cnt_sel = '0;
        #2;
        chk("rst_ack", Ack, 0);
        chk("rst_evt_valid", Evt_valid, 0);
        chk("rst_evt_ch", Evt_ch, 0);
        chk("rst_evt_rise", Evt_rise, 0);
        for (int c = 0; c < N; c++) begin
            Cnt_sel = IW'(c);
            #1 chk("rst_cnt", Cnt_out, 0);
        end

        // round-robin order from reset
        do_reset();
        Req = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("rr_ack", Ack, exp_ack[i]);
        end
        Req = '0;
        repeat (2) @(negedge Clk);

        // first sample and changes on channel 2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(2, tv[i].b, ev, rise, evch);
            chk("chg_evt", ev, tv[i].ev);
            if (tv[i].ev) begin
                chk("chg_ch", evch, 2);
                chk("chg_rise", rise, tv[i].rise);
            end
        end
        Cnt_sel = 2'd2;
        #1 chk("chg_cnt", Cnt_out, 2);

        // back-pressure with another requester waiting
        Evt_ready = 1'b0;
        send(2, 1'b1, ev, rise, evch);
        chk("bp_evt", ev, 1);
        Req[1] = 1'b1; Bit[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_valid", Evt_valid, 1);
            chk("bp_ch", Evt_ch, 2);
            chk("bp_rise", Evt_rise, 1);
            chk("bp_ack", Ack, 0);
            chk("bp_cnt", Cnt_out, 2);
        end
        Evt_ready = 1'b1;
        @(negedge Clk);
        chk("bp_valid_clr", Evt_valid, 0);
        chk("bp_cnt_inc", Cnt_out, 3);
        wait_ack(1, "bp_next_ack");
        Req[1] = 1'b0;
        @(negedge Clk);
        chk("bp_next_noevt", Evt_valid, 0);

        // enable drop clears context and blocks grants
        do_reset();
        send(1, 1'b1, ev, rise, evch);
        chk("en_first", ev, 0);
        Ch_en[1] = 1'b0; Req[1] = 1'b1; Bit[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("en_no_ack", Ack, 0);
        end
        Ch_en[1] = 1'b1;
        wait_ack(1, "en_ack");
        Req[1] = 1'b0;
        @(negedge Clk);
        chk("en_no_evt", Evt_valid, 0);
        Cnt_sel = 2'd1;
        #1 chk("en_cnt", Cnt_out, 0);

        // counter saturation on the narrow-counter instance
        do_reset();
        Cnt_sel = 2'd0;
        for (int k = 0; k <= 6; k++) begin
            send(0, 1'(k % 2), ev, rise, evch);
            #1;
            chk("sat_cnt2", Cnt_out_s, (k > 3) ? 3 : k);
            chk("sat_cnt8", Cnt_out, k);
        end

        // reset in the middle of EMIT
        do_reset();
        Cnt_sel = 2'd3;
        send(3, 1'b0, ev, rise, evch);
        send(3, 1'b1, ev, rise, evch);
        Evt_ready = 1'b0;
        send(3, 1'b0, ev, rise, evch);
        chk("mid_emit", ev, 1);
        #1 chk("mid_cnt_before", Cnt_out, 1);
        Clr_n = 1'b0;
        #1;
        chk("mid_valid", Evt_valid, 0);
        chk("mid_cnt", Cnt_out, 0);
        @(negedge Clk);
        Clr_n = 1'b1; Evt_ready = 1'b1;
        @(negedge Clk);
        send(3, 1'b1, ev, rise, evch);
        chk("mid_first_noevt", ev, 0);

        // randomized run against the model
        do_reset();
        for (int c = 0; c < N; c++) begin
            m_has[c] = 1'b0; m_last[c] = 1'b0; m_cnt[c] = 0;
        end
        exp_q.delete();
        for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 60; i++) rand_cycle(1'b1);
        chk("rnd_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
